ctrl_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the CPU core. It steps each instruction through FETCH, DECODE, REGREAD, EXECUTE, optional MEM and WRITEBACK. It owns the memory request handshake for fetch, load and store, and provides a latched instruction register, a register-file write strobe, a stall input, a memory timeout fault and a HALT state.

---
 rtl/ctrl_sequencer_pkg.sv | 31 +++
 rtl/ctrl_sequencer_mem_req_ctrl.sv | 77 +++++++
 rtl/ctrl_sequencer.sv | 151 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// one-hot state encoding, opcode values and memory request type codes.
package ctrl_sequencer_pkg;

    // One-hot FSM states; the encoding is visible on O_state.
    typedef enum logic [6:0] {
        ST_FETCH     = 7'b0000001,
        ST_DECODE    = 7'b0000010,
        ST_REGREAD   = 7'b0000100,
        ST_EXECUTE   = 7'b0001000,
        ST_MEM       = 7'b0010000,
        ST_WRITEBACK = 7'b0100000,
        ST_HALT      = 7'b1000000
    } state_e;

    // Opcodes that change the control flow; every other value is an ALU op.
    localparam logic [3:0] OPC_READ  = 4'h8;
    localparam logic [3:0] OPC_WRITE = 4'h9;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    // Memory request type presented with the request strobe.
    localparam logic [1:0] MOP_FETCH = 2'b00;
    localparam logic [1:0] MOP_READ  = 2'b01;
    localparam logic [1:0] MOP_WRITE = 2'b10;

    // Request type for a data access made from the MEM state.
    function automatic logic [1:0] mem_op_for(input logic [3:0] opc);
        return (opc == OPC_WRITE) ? MOP_WRITE : MOP_READ;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_mem_req_ctrl.sv
// Memory request handshake shared by FETCH and MEM: owns the pending flag,
// the one-cycle request strobe and the response timeout counter.
// o_done / o_timeout are combinational and valid only in a pending cycle.
module mem_req_ctrl
    import ctrl_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_active,
    input  logic       i_is_write,
    input  logic [1:0] i_op,
    input  logic       i_mem_ready,
    input  logic       i_data_ready,
    output logic       o_execute,
    output logic [1:0] o_mem_op,
    output logic       o_done,
    output logic       o_timeout
);

    localparam bit              TMO_EN    = (MEM_TIMEOUT != 0);
    // Last counter value before the limit is reached in the current wait cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

    logic             r_pending, w_pending_nxt;
    logic [TMO_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_execute, w_execute_nxt;
    logic [1:0]       r_mem_op, w_mem_op_nxt;
    logic             w_issue;

    assign w_issue   = i_active & ~r_pending & i_mem_ready;
    // Writes finish one cycle after the request without a data handshake.
    assign o_done    = r_pending & (i_is_write | i_data_ready);
    // A response in the same cycle as the limit wins over the fault.
    assign o_timeout = r_pending & ~i_is_write & ~i_data_ready & TMO_EN & (r_cnt == TMO_LAST);

    // Next-state of the handshake: issue, complete/abandon, or keep counting.
    always_comb begin
        w_pending_nxt = r_pending;
        w_cnt_nxt     = r_cnt;
        w_execute_nxt = 1'b0;
        w_mem_op_nxt  = MOP_FETCH;
        if (w_issue) begin
            w_pending_nxt = 1'b1;
            w_cnt_nxt     = {TMO_W{1'b0}};
            w_execute_nxt = 1'b1;
            w_mem_op_nxt  = i_op;
        end else if (o_done || o_timeout) begin
            w_pending_nxt = 1'b0;
        end else if (r_pending) begin
            w_cnt_nxt = r_cnt + TMO_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Handshake registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_cnt     <= {TMO_W{1'b0}};
            r_execute <= 1'b0;
            r_mem_op  <= MOP_FETCH;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
            r_execute <= w_execute_nxt;
            r_mem_op  <= w_mem_op_nxt;
        end
    end

    assign o_execute = r_execute;
    assign o_mem_op  = r_mem_op;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH, DECODE, REGREAD, EXECUTE, optional MEM and WRITEBACK, with a
// stall hold in the decode/execute stages and a terminal HALT state.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int OPC_LSB     = 12,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] I_instruction,
    input  logic               I_mem_ready,
    input  logic               I_data_ready,
    input  logic               I_stall,
    output logic [6:0]         O_state,
    output logic               O_execute,
    output logic [1:0]         O_mem_op,
    output logic [INSTR_W-1:0] O_instr,
    output logic               O_reg_we,
    output logic               O_retire,
    output logic               O_fault
);

    state_e             r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic               r_reg_we, w_reg_we_nxt;
    logic               r_retire, w_retire_nxt;
    logic               r_fault, w_fault_nxt;
    logic [3:0]         w_opc;
    logic               w_active, w_is_write, w_done, w_timeout;
    logic [1:0]         w_req_op;

    assign w_opc      = r_instr[OPC_LSB+3:OPC_LSB];
    assign w_active   = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_is_write = (r_state == ST_MEM) && (w_opc == OPC_WRITE);
    assign w_req_op   = (r_state == ST_MEM) ? mem_op_for(w_opc) : MOP_FETCH;

    mem_req_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_mem_req (
        .clk          (clk),
        .rst_n        (reset),
        .i_active     (w_active),
        .i_is_write   (w_is_write),
        .i_op         (w_req_op),
        .i_mem_ready  (I_mem_ready),
        .i_data_ready (I_data_ready),
        .o_execute    (O_execute),
        .o_mem_op     (O_mem_op),
        .o_done       (w_done),
        .o_timeout    (w_timeout)
    );

    // Next state and next registered outputs; strobes default low each cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_instr_nxt  = r_instr;
        w_reg_we_nxt = 1'b0;
        w_retire_nxt = 1'b0;
        w_fault_nxt  = r_fault;
        case (r_state)
            ST_FETCH: begin
                if (w_timeout) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (w_done) begin
                    w_instr_nxt = I_instruction;
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (I_stall) begin
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_state_nxt = ST_REGREAD;
                end
            end
            ST_REGREAD: begin
                if (I_stall) begin
                    w_state_nxt = ST_REGREAD;
                end else begin
                    w_state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (I_stall) begin
                    w_state_nxt = ST_EXECUTE;
                end else if ((w_opc == OPC_READ) || (w_opc == OPC_WRITE)) begin
                    w_state_nxt = ST_MEM;
                end else if (w_opc == OPC_HALT) begin
                    w_retire_nxt = 1'b1;
                    w_state_nxt  = ST_HALT;
                end else begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (w_timeout) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (w_done) begin
                    w_state_nxt = ST_WRITEBACK;
                end else begin
                    w_state_nxt = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                w_reg_we_nxt = (w_opc != OPC_WRITE);
                w_retire_nxt = 1'b1;
                w_state_nxt  = ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                // Corrupted one-hot value: restart cleanly from FETCH.
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_FETCH;
            r_instr  <= {INSTR_W{1'b0}};
            r_reg_we <= 1'b0;
            r_retire <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_instr  <= w_instr_nxt;
            r_reg_we <= w_reg_we_nxt;
            r_retire <= w_retire_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    assign O_state  = r_state;
    assign O_instr  = r_instr;
    assign O_reg_we = r_reg_we;
    assign O_retire = r_retire;
    assign O_fault  = r_fault;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: an instruction-level model plans the expected
// state sequence and output pulses for each instruction from its phase
// lengths (waits, stalls, response delays) and compares every cycle.
module tb_ctrl_sequencer;

    localparam int TMO = 4;
    localparam logic [6:0] S_F = 7'b0000001, S_D = 7'b0000010, S_R = 7'b0000100,
                           S_E = 7'b0001000, S_M = 7'b0010000, S_W = 7'b0100000,
                           S_H = 7'b1000000;
    localparam logic [3:0] OP_RD = 4'h8, OP_WR = 4'h9, OP_HLT = 4'hF;

    logic        clk = 1'b0, reset = 1'b0;
    logic        I_mem_ready = 1'b0, I_data_ready = 1'b0, I_stall = 1'b0;
    logic [15:0] I_instruction = 16'h0000;
    logic [6:0]  O_state;
    logic        O_execute, O_reg_we, O_retire, O_fault;
    logic [1:0]  O_mem_op;
    logic [15:0] O_instr;

    ctrl_sequencer #(.INSTR_W(16), .OPC_LSB(12), .MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .reset(reset), .I_instruction(I_instruction),
        .I_mem_ready(I_mem_ready), .I_data_ready(I_data_ready), .I_stall(I_stall),
        .O_state(O_state), .O_execute(O_execute), .O_mem_op(O_mem_op),
        .O_instr(O_instr), .O_reg_we(O_reg_we), .O_retire(O_retire), .O_fault(O_fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc_no = 0, rr_cnt = 0;
    bit g_dir = 1'b0;
    // model: persistent registers and pulses expected in the next cycle
    logic [15:0] m_instr = 16'h0000;
    logic        m_fault = 1'b0, c_exec = 1'b0, c_we = 1'b0, c_ret = 1'b0;
    logic [1:0]  c_op = 2'b00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, O_state, 7'b0000001);
        chk({tag, "_execute"}, O_execute, 1'b0);
        chk({tag, "_mem_op"}, O_mem_op, 2'b00);
        chk({tag, "_instr"}, O_instr, 16'h0000);
        chk({tag, "_reg_we"}, O_reg_we, 1'b0);
        chk({tag, "_retire"}, O_retire, 1'b0);
        chk({tag, "_fault"}, O_fault, 1'b0);
    endtask

    // noise for inputs that must be ignored in the current cycle
    function automatic logic rb();
        return g_dir ? 1'b1 : 1'($urandom % 2);
    endfunction

    // One clock cycle: compare outputs with the model, drive inputs, advance.
    task automatic cyc(input logic [6:0] st, input logic mr, input logic dr,
                       input logic stl, input logic [15:0] ins, input bit abort);
        chk("state", O_state, st);
        chk("execute", O_execute, c_exec);
        if (c_exec) chk("mem_op", O_mem_op, c_op);
        chk("instr", O_instr, m_instr);
        chk("reg_we", O_reg_we, c_we);
        chk("retire", O_retire, c_ret);
        chk("fault", O_fault, m_fault);
        if (O_state === S_R) rr_cnt++;
        c_exec = 1'b0; c_we = 1'b0; c_ret = 1'b0;
        I_mem_ready = mr; I_data_ready = dr; I_stall = stl; I_instruction = ins;
        if (abort) begin
            #2 reset = 1'b0;
            #1 chk_reset("async_rst");
            m_instr = 16'h0000; m_fault = 1'b0;
        end
        @(posedge clk); #1;
        cyc_no++;
    endtask

    task automatic do_reset();
        reset = 1'b0; I_mem_ready = 1'b0; I_data_ready = 1'b0; I_stall = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            cyc_no++;
            chk_reset("reset");
        end
        reset = 1'b1;
        m_instr = 16'h0000; m_fault = 1'b0; c_exec = 1'b0; c_we = 1'b0; c_ret = 1'b0;
    endtask

    // Request handshake: nw cycles without mem_ready, the request cycle, then
    // the response on pending cycle n (n > TMO means no response -> fault).
    // res: 0 complete, 1 timeout fault, 2 aborted by reset.
    task automatic hs(input logic [6:0] st, input logic [1:0] op, input bit wr,
                      input int nw, input int n, input logic [15:0] ins,
                      input bit abort, output int res);
        res = 0;
        for (int i = 0; i < nw; i++) cyc(st, 1'b0, rb(), rb(), 16'($urandom), 1'b0);
        cyc(st, 1'b1, rb(), rb(), 16'($urandom), 1'b0);
        c_exec = 1'b1; c_op = op;
        if (wr) begin
            cyc(st, rb(), rb(), rb(), 16'($urandom), 1'b0);
            return;
        end
        if (abort) begin
            cyc(st, rb(), 1'b0, rb(), 16'($urandom), 1'b1);
            res = 2;
            return;
        end
        for (int i = 1; i <= TMO; i++) begin
            if (i == n) begin
                cyc(st, rb(), 1'b1, rb(), ins, 1'b0);
                if (st == S_F) m_instr = ins;
                return;
            end
            cyc(st, rb(), 1'b0, rb(), 16'($urandom), 1'b0);
        end
        m_fault = 1'b1;
        res = 1;
    endtask

    task automatic stage(input logic [6:0] st, input int ns);
        for (int i = 0; i < ns; i++) cyc(st, rb(), rb(), 1'b1, 16'($urandom), 1'b0);
        cyc(st, rb(), rb(), 1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic halt_cycles();
        for (int i = 0; i < 4; i++) cyc(S_H, 1'b1, rb(), rb(), 16'($urandom), 1'b0);
    endtask

    // Whole instruction; ended=1 when the episode can go no further.
    task automatic run_instr(input logic [15:0] ins, input int f_nw, input int f_n,
                             input int m_nw, input int m_n, input int s_d,
                             input int s_r, input int s_e, input bit abort,
                             output bit ended);
        int res;
        logic [3:0] opc;
        ended = 1'b1;
        opc = ins[15:12];
        hs(S_F, 2'b00, 1'b0, f_nw, f_n, ins, 1'b0, res);
        if (res != 0) begin halt_cycles(); return; end
        stage(S_D, s_d);
        stage(S_R, s_r);
        stage(S_E, s_e);
        if (opc == OP_HLT) begin
            c_ret = 1'b1;
            halt_cycles();
            return;
        end
        if (opc == OP_RD || opc == OP_WR) begin
            hs(S_M, (opc == OP_WR) ? 2'b10 : 2'b01, opc == OP_WR, m_nw, m_n,
               16'($urandom), abort, res);
            if (res == 1) begin halt_cycles(); return; end
            if (res == 2) return;
        end
        cyc(S_W, rb(), rb(), rb(), 16'($urandom), 1'b0);
        c_we = (opc != OP_WR);
        c_ret = 1'b1;
        ended = 1'b0;
    endtask

    function automatic int rstall();
        return ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    function automatic int rresp();
        return ($urandom % 12 == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        bit ended;
        logic [15:0] ins;
        int k;

        // directed episode: literal expectations pin the model
        g_dir = 1'b1;
        do_reset();
        st0 = cyc_no;
        run_instr(16'h1234, 0, 1, 0, 1, 0, 0, 0, 1'b0, ended);
        chk("pin_alu_latency", cyc_no - st0, 6);
        chk("pin_alu_retire", O_retire, 1'b1);
        chk("pin_alu_reg_we", O_reg_we, 1'b1);
        chk("pin_alu_instr", O_instr, 16'h1234);
        st0 = cyc_no;
        run_instr(16'h8abc, 0, 1, 0, 3, 0, 0, 0, 1'b0, ended);
        chk("pin_read_latency", cyc_no - st0, 10);
        chk("pin_read_reg_we", O_reg_we, 1'b1);
        st0 = cyc_no;
        run_instr(16'h9055, 0, 1, 0, 1, 0, 0, 0, 1'b0, ended);
        chk("pin_write_latency", cyc_no - st0, 8);
        chk("pin_write_reg_we", O_reg_we, 1'b0);
        chk("pin_write_retire", O_retire, 1'b1);
        rr_cnt = 0;
        st0 = cyc_no;
        run_instr(16'h2001, 0, 1, 0, 1, 0, 4, 0, 1'b0, ended);
        chk("pin_stall_regread_cycles", rr_cnt, 5);
        chk("pin_stall_latency", cyc_no - st0, 10);
        run_instr(16'h8001, 0, 1, 0, 4, 0, 0, 0, 1'b0, ended);
        chk("pin_late_resp_no_fault", O_fault, 1'b0);
        run_instr(16'h8002, 0, 1, 0, 5, 0, 0, 0, 1'b0, ended);
        chk("pin_timeout_fault", O_fault, 1'b1);
        chk("pin_timeout_halt", O_state, 7'b1000000);

        do_reset();
        run_instr(16'h3333, 0, 1, 0, 1, 0, 0, 0, 1'b0, ended);
        run_instr(16'h8444, 0, 1, 0, 2, 0, 0, 0, 1'b1, ended);
        do_reset();
        run_instr(16'h4321, 0, 2, 0, 1, 0, 0, 0, 1'b0, ended);
        chk("pin_after_abort_instr", O_instr, 16'h4321);
        run_instr(16'hF000, 0, 1, 0, 1, 0, 0, 0, 1'b0, ended);
        chk("pin_halt_state", O_state, 7'b1000000);

        // randomized episodes
        g_dir = 1'b0;
        for (int e = 0; e < 40; e++) begin
            do_reset();
            for (int j = 0; j < 10; j++) begin
                ins = 16'($urandom);
                k = int'($urandom % 20);
                if (k < 5)       ins[15:12] = OP_RD;
                else if (k < 10) ins[15:12] = OP_WR;
                else if (k == 10) ins[15:12] = OP_HLT;
                else             ins[15:12] = 4'($urandom % 8);
                run_instr(ins, int'($urandom_range(0, 2)), rresp(),
                          int'($urandom_range(0, 2)), rresp(),
                          rstall(), rstall(), rstall(),
                          (ins[15:12] == OP_RD) && ($urandom % 15 == 0), ended);
                if (ended) break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
